// File: rtl/drum_mul_arbiter_pkg.sv
// Shared types and sizing helpers for the DRUM multiplier arbiter.
package drum_mul_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } drum_arb_state_t;

    localparam int DEF_N = 4;
    localparam int DEF_M = 4;

    function automatic int id_width(input int nreq);
        return (nreq < 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/drum_mul_arbiter_if.sv
// Requester, shared-multiplier and response signals of the DRUM arbiter.
interface drum_mul_arbiter_if #(
    parameter int N    = drum_mul_arbiter_pkg::DEF_N,
    parameter int M    = drum_mul_arbiter_pkg::DEF_M,
    parameter int NREQ = 4
);
    localparam int ID_W = drum_mul_arbiter_pkg::id_width(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*M-1:0] req_b;
    logic [N-1:0]      mul_a;
    logic [M-1:0]      mul_b;
    logic [N+M-1:0]    mul_r;
    logic              resp_valid;
    logic              resp_ready;
    logic [N+M-1:0]    resp_r;
    logic [ID_W-1:0]   resp_id;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, mul_r, resp_ready,
        input  req_ready, mul_a, mul_b, resp_valid, resp_r, resp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_r, resp_ready,
        output req_ready, mul_a, mul_b, resp_valid, resp_r, resp_id, busy
    );

endinterface

// File: rtl/drum_mul_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter
    import drum_mul_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [ID_W-1:0] gnt_idx,
    output logic            gnt_any
);

    always_comb begin
        int unsigned j;
        j          = 0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_any    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            // explicit wrap keeps non-power-of-two NREQ correct
            if (j >= NREQ) j = j - NREQ;
            if (!gnt_any && req[j]) begin
                gnt_any       = 1'b1;
                gnt_idx       = ID_W'(j);
                gnt_onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/drum_mul_arbiter.sv
// Time-shares one external DRUM multiplier among NREQ requesters, round-robin,
// returning each tagged product through a single valid/ready response port.
//
//   state | meaning
//   IDLE  | waiting for a request; grant combinationally, latch operands
//   BUSY  | operands held on the multiplier for MUL_LAT cycles
//   DONE  | response valid, held until the consumer takes it
module drum_mul_arbiter
    import drum_mul_arbiter_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int M       = DEF_M,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 1
) (
    input logic              clk,
    input logic              rst,
    drum_mul_arbiter_if.slave bus
);

    localparam int ID_W  = id_width(NREQ);
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    drum_arb_state_t state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  tag;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     mul_a;
    logic [M-1:0]     mul_b;
    logic [N+M-1:0]   resp_r;
    logic [ID_W-1:0]  resp_id;
    logic             resp_valid;

    logic [NREQ-1:0]  gnt_onehot;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_any;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr (
        .req        (bus.req_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    assign bus.req_ready  = (!rst && state == IDLE) ? gnt_onehot : '0;
    assign bus.mul_a      = mul_a;
    assign bus.mul_b      = mul_b;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_r     = resp_r;
    assign bus.resp_id    = resp_id;
    assign bus.busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            tag        <= '0;
            cnt        <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            resp_r     <= '0;
            resp_id    <= '0;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        mul_a  <= bus.req_a[int'(gnt_idx)*N +: N];
                        mul_b  <= bus.req_b[int'(gnt_idx)*M +: M];
                        tag    <= gnt_idx;
                        rr_ptr <= (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + ID_W'(1);
                        cnt    <= CNT_W'(MUL_LAT-1);
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        resp_r     <= bus.mul_r;
                        resp_id    <= tag;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    // no new grant on the handshake edge; IDLE re-arbitrates next cycle
                    if (bus.resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
